// File: rtl/mul_const_sched.sv
// Shared shift-add constant multiplier: a round-robin arbiter picks one requester,
// then the sequencer emits d*1, d*3, d*7 and d*8 for that operand in order.
module mul_const_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int OW   = DW + 3,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OW-1:0]        out_data_o,
    output logic [IDW-1:0]       out_id_o,
    output logic [1:0]           out_step_o,
    output logic                 out_last_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S3   = 3'd2,
        ST_S7   = 3'd3,
        ST_S8   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]   d_q, d_d;
    logic            out_valid_q, out_valid_d;
    logic [OW-1:0]   out_data_q, out_data_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic [1:0]      out_step_q, out_step_d;
    logic            out_last_q, out_last_d;

    logic            found_s;
    logic [IDW-1:0]  cand_s;
    logic [IDW-1:0]  grant_id_s;
    logic [DW-1:0]   grant_data_s;
    logic            accept_s;
    logic            advance_s;

    // Multiply by 1, 3, 7 or 8 using only shifts and one add/subtract.
    function automatic logic [OW-1:0] scale(input logic [DW-1:0] d, input logic [1:0] step);
        logic [OW-1:0] dx;
        dx = OW'(d);
        case (step)
            2'd0:    scale = dx;
            2'd1:    scale = (dx << 1) + dx;
            2'd2:    scale = (dx << 3) - dx;
            2'd3:    scale = dx << 3;
            default: scale = dx;
        endcase
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found_s    = 1'b0;
        cand_s     = '0;
        grant_id_s = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found_s && req_valid_i[cand_s]) begin
                found_s    = 1'b1;
                grant_id_s = cand_s;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Operand of the granted requester.
    always_comb begin
        grant_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_s == IDW'(i)) begin
                grant_data_s = req_data_i[i*DW +: DW];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
    end

    assign accept_s  = ((state_q == ST_IDLE) || ((state_q == ST_S8) && out_ready_i)) && found_s;
    assign advance_s = out_valid_q && out_ready_i;

    // One-hot accept strobe, only in the accept cycle.
    always_comb begin
        req_ready_o = '0;
        if (accept_s) begin
            req_ready_o[grant_id_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    // Next-state and output-register logic; everything holds unless accepted or advanced.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_step_d  = out_step_q;
        out_last_d  = out_last_q;
        if (accept_s) begin
            state_d     = ST_S1;
            ptr_d       = grant_id_s;
            d_d         = grant_data_s;
            out_valid_d = 1'b1;
            out_data_d  = scale(grant_data_s, 2'd0);
            out_id_d    = grant_id_s;
            out_step_d  = 2'd0;
            out_last_d  = 1'b0;
        end else if (advance_s) begin
            case (state_q)
                ST_S1: begin
                    state_d    = ST_S3;
                    out_data_d = scale(d_q, 2'd1);
                    out_step_d = 2'd1;
                end
                ST_S3: begin
                    state_d    = ST_S7;
                    out_data_d = scale(d_q, 2'd2);
                    out_step_d = 2'd2;
                end
                ST_S7: begin
                    state_d    = ST_S8;
                    out_data_d = scale(d_q, 2'd3);
                    out_step_d = 2'd3;
                    out_last_d = 1'b1;
                end
                ST_S8: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            d_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_step_q  <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_step_q  <= out_step_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_id_o    = out_id_q;
    assign out_step_o  = out_step_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_const_sched.sv
// Bench for mul_const_sched: operand table, directed corner sequences and a
// randomized run, all checked against a step-based reference model.
module tb_mul_const_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int OW   = DW + 3;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [OW-1:0]       out_data;
    logic [IDW-1:0]      out_id;
    logic [1:0]          out_step;
    logic                out_last;
    logic                busy;

    mul_const_sched #(.NREQ(NREQ), .DW(DW), .OW(OW), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_id_o    (out_id),
        .out_step_o  (out_step),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Samples taken at the falling edge of the most recent tick.
    logic [NREQ-1:0] s_ready;
    logic            s_valid, s_last, s_busy;
    logic [OW-1:0]   s_data;
    logic [IDW-1:0]  s_id;
    logic [1:0]      s_step;
    bit              auto_drop;

    // Reference model: an operand with a step index 0..3 and a multiplier table.
    int m_active, m_step, m_d, m_id, m_ptr;
    int mult [4] = '{1, 3, 7, 8};

    typedef struct {
        int req;
        int d;
        int e1, e3, e7, e8;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_step = 0; m_d = 0; m_id = 0; m_ptr = NREQ - 1;
    endtask

    task automatic model_step();
        int g;
        int exp_ready;
        g = -1;
        exp_ready = 0;
        if ((m_active == 0 || (m_step == 3 && out_ready)) && req_valid != 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_ready = 1 << g;
        end
        chk("req_ready", s_ready, exp_ready);
        chk("out_valid", s_valid, m_active);
        chk("busy", s_busy, m_active);
        if (m_active != 0) begin
            chk("out_data", s_data, m_d * mult[m_step]);
            chk("out_id", s_id, m_id);
            chk("out_step", s_step, m_step);
            chk("out_last", s_last, (m_step == 3) ? 1 : 0);
        end
        if (g >= 0) begin
            m_active = 1; m_step = 0; m_id = g; m_ptr = g;
            m_d = int'(req_data[g*DW +: DW]);
        end else if (m_active != 0 && out_ready) begin
            if (m_step == 3) m_active = 0;
            else m_step++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_ready = req_ready; s_valid = out_valid; s_data = out_data; s_id = out_id;
        s_step = out_step; s_last = out_last; s_busy = busy;
        model_step();
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~s_ready;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        out_ready = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        tbl[0] = '{0,   5,   5,  15,   35,   40};
        tbl[1] = '{1, 255, 255, 765, 1785, 2040};
        tbl[2] = '{2,   0,   0,   0,    0,    0};
        tbl[3] = '{3,   1,   1,   3,    7,    8};
        tbl[4] = '{0, 128, 128, 384,  896, 1024};
        tbl[5] = '{2,  37,  37, 111,  259,  296};

        rst = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0; auto_drop = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_id", out_id, 0);
        chk("rst_step", out_step, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Operand table: single requester, full four-step sequence with out_ready high.
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            req_data[tbl[v].req*DW +: DW] = DW'(tbl[v].d);
            req_valid = 4'b0001 << tbl[v].req;
            tick();
            chk("tbl_grant", s_ready, 1 << tbl[v].req);
            tick();
            chk("tbl_x1", s_data, tbl[v].e1);
            chk("tbl_id", s_id, tbl[v].req);
            chk("tbl_last1", s_last, 0);
            tick();
            chk("tbl_x3", s_data, tbl[v].e3);
            tick();
            chk("tbl_x7", s_data, tbl[v].e7);
            tick();
            chk("tbl_x8", s_data, tbl[v].e8);
            chk("tbl_last8", s_last, 1);
            tick();
            chk("tbl_idle", s_valid, 0);
        end

        // All requesters held valid: grants rotate 0,1,2,3,0 every four cycles.
        do_reset();
        auto_drop = 1'b0;
        out_ready = 1'b1;
        req_data  = {8'd4, 8'd3, 8'd2, 8'd1};
        req_valid = 4'b1111;
        for (int n = 0; n <= 16; n++) begin
            tick();
            if (n % 4 == 0) chk("rr_grant", s_ready, 1 << ((n / 4) % 4));
            if (n % 4 == 1) chk("rr_x1", s_data, (n / 4) + 1);
        end
        auto_drop = 1'b1;
        drain();

        // Backpressure during the x3 step holds the output stable.
        req_data[7:0] = 8'd5;
        req_valid = 4'b0001;
        tick();
        tick();
        chk("bp_x1", s_data, 5);
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_hold_data", s_data, 15);
            chk("bp_hold_step", s_step, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_x3_taken", s_data, 15);
        tick();
        chk("bp_x7", s_data, 35);
        tick();
        chk("bp_x8", s_data, 40);
        drain();

        // Reset in S7 abandons the operand and restores requester 0 priority.
        req_data[2*DW +: DW] = 8'd9;
        req_valid = 4'b0100;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 4'b1101;
        tick();
        chk("rst_mid_grant", s_ready, 4'b0001);
        drain();

        // Requester 2 withdraws before its grant; requester 3 is served instead.
        req_data  = {8'd30, 8'd20, 8'd0, 8'd5};
        req_valid = 4'b0001;
        tick();
        req_valid = req_valid | 4'b1100;
        repeat (2) tick();
        req_valid[2] = 1'b0;
        tick();
        tick();
        chk("skip_grant", s_ready, 4'b1000);
        tick();
        chk("skip_id", s_id, 3);
        chk("skip_x1", s_data, 30);
        drain();

        // Randomized traffic with random backpressure against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_data[i*DW +: DW] = DW'($urandom_range(0, 255));
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
